// File: rtl/priority_matrix_updater_pkg.sv
// Shared types and helpers for the priority-matrix arbiter and its updater.
// Matrix convention: row i bit j = 1 means requester i beats requester j.
package prio_matrix_pkg;
    localparam int MAX_N = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    typedef logic [MAX_N-1:0] row_t;
    typedef logic [MAX_N-1:0][MAX_N-1:0] mat_t;

    // Index 0 highest priority: i beats j exactly when j > i.
    function automatic mat_t reset_matrix(input int n);
        mat_t m;
        m = '0;
        for (int i = 0; i < MAX_N; i++) begin
            for (int j = 0; j < MAX_N; j++) begin
                m[i][j] = (i < n) && (j < n) && (j > i);
            end
        end
        return m;
    endfunction

    function automatic logic is_onehot(input row_t v);
        return (v != '0) && ((v & (v - row_t'(1))) == '0);
    endfunction
endpackage

// File: rtl/priority_matrix_updater_if.sv
// Grant-side and matrix-side signal bundle between arbiter/config logic and the updater.
interface priority_matrix_updater_if #(parameter int N = 3);
    logic         valid_gnt;
    logic [N-1:0] gnt;
    logic [N-1:0] req;
    logic         cfg_load;
    logic [N-1:0] cfg_matrix [N-1:0];
    logic [N-1:0] matrix_out [N-1:0];
    logic         busy;
    logic         upd_done;
    logic         err_multi_gnt;
    logic         err_overrun;

    modport master (
        output valid_gnt, gnt, req, cfg_load, cfg_matrix,
        input  matrix_out, busy, upd_done, err_multi_gnt, err_overrun
    );

    modport slave (
        input  valid_gnt, gnt, req, cfg_load, cfg_matrix,
        output matrix_out, busy, upd_done, err_multi_gnt, err_overrun
    );
endinterface

// File: rtl/priority_matrix_updater_starve_counter.sv
// Saturating count of grant events a requester has lost; clr wins over inc.
module starve_counter #(
    parameter int LIMIT = 4,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != W'(LIMIT))) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign sat = (count_reg == W'(LIMIT));
endmodule

// File: rtl/priority_matrix_updater.sv
// Rewrites the arbiter's priority matrix from grant events: the winner drops to
// lowest priority and a requester that keeps losing is promoted to highest.
module priority_matrix_updater
    import prio_matrix_pkg::*;
#(
    parameter int N            = 3,
    parameter int STARVE_LIMIT = 4
) (
    input logic                      clk,
    input logic                      rst,
    priority_matrix_updater_if.slave bus
);
    localparam int   CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam mat_t RESET_MAT = reset_matrix(N);

    state_t       state_reg, state_next;
    logic [N-1:0] gnt_reg, req_reg;
    logic [N-1:0] matrix_reg [N-1:0];
    logic [N-1:0] apply_mat  [N-1:0];
    logic [N-1:0] cfg_mat    [N-1:0];
    logic         upd_done_reg, upd_done_next;
    logic         err_multi_reg, err_overrun_reg;
    logic         set_multi;
    logic [N-1:0] cnt_inc, cnt_clr, cnt_sat, promote;
    row_t         gnt_ext;
    logic         gnt_onehot, gnt_multi;

    always_comb begin
        gnt_ext          = '0;
        gnt_ext[N-1:0]   = gnt_reg;
    end
    assign gnt_onehot = is_onehot(gnt_ext);
    assign gnt_multi  = !gnt_onehot && (gnt_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cnt
            starve_counter #(.LIMIT(STARVE_LIMIT), .W(CNT_W)) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (cnt_inc[gi]),
                .clr (cnt_clr[gi]),
                .sat (cnt_sat[gi])
            );
            assign bus.matrix_out[gi] = matrix_reg[gi];
        end
    endgenerate

    // Only the lowest saturated index is promoted; the rest wait for a later event.
    always_comb begin
        promote = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cnt_sat[i]) begin
                promote    = '0;
                promote[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_inc = '0;
        cnt_clr = '0;
        if (bus.cfg_load) begin
            cnt_clr = '1;
        end else if (state_reg == S_CHECK && !gnt_multi) begin
            cnt_clr = gnt_reg;
            cnt_inc = req_reg & ~gnt_reg;
        end else if (state_reg == S_APPLY) begin
            cnt_clr = promote;
        end
    end

    // Demote the winner first, then promote the starved requester over everyone.
    always_comb begin
        apply_mat = matrix_reg;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (gnt_onehot && gnt_reg[i]) begin
                    apply_mat[i][j] = 1'b0;
                end else if (gnt_onehot && gnt_reg[j]) begin
                    apply_mat[i][j] = 1'b1;
                end
                if (i != j) begin
                    if (promote[i]) begin
                        apply_mat[i][j] = 1'b1;
                    end else if (promote[j]) begin
                        apply_mat[i][j] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i < j) begin
                    cfg_mat[i][j] = bus.cfg_matrix[i][j];
                end else if (i > j) begin
                    cfg_mat[i][j] = ~bus.cfg_matrix[j][i];
                end else begin
                    cfg_mat[i][j] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        upd_done_next = 1'b0;
        set_multi     = 1'b0;
        case (state_reg)
            S_IDLE:  if (bus.valid_gnt) state_next = S_CHECK;
            S_CHECK: begin
                set_multi  = gnt_multi;
                state_next = gnt_multi ? S_IDLE : S_APPLY;
            end
            S_APPLY: begin
                upd_done_next = 1'b1;
                state_next    = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (bus.cfg_load) begin
            state_next    = S_IDLE;
            upd_done_next = 1'b0;
            set_multi     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            gnt_reg         <= '0;
            req_reg         <= '0;
            upd_done_reg    <= 1'b0;
            err_multi_reg   <= 1'b0;
            err_overrun_reg <= 1'b0;
            for (int i = 0; i < N; i++) begin
                matrix_reg[i] <= RESET_MAT[i][N-1:0];
            end
        end else begin
            state_reg    <= state_next;
            upd_done_reg <= upd_done_next;
            if (state_reg == S_IDLE && bus.valid_gnt) begin
                gnt_reg <= bus.gnt;
                req_reg <= bus.req;
            end
            if (bus.cfg_load) begin
                matrix_reg <= cfg_mat;
            end else if (state_reg == S_APPLY) begin
                matrix_reg <= apply_mat;
            end
            if (set_multi) begin
                err_multi_reg <= 1'b1;
            end
            if (bus.valid_gnt && state_reg != S_IDLE) begin
                err_overrun_reg <= 1'b1;
            end
        end
    end

    assign bus.busy          = (state_reg != S_IDLE);
    assign bus.upd_done      = upd_done_reg;
    assign bus.err_multi_gnt = err_multi_reg;
    assign bus.err_overrun   = err_overrun_reg;
endmodule

// File: tb/tb_priority_matrix_updater.sv
// Bench for priority_matrix_updater: directed literal cases, then random events
// compared every cycle against a transaction-level "who beats whom" model.
module tb_priority_matrix_updater;
    localparam int N   = 3;
    localparam int LIM = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    priority_matrix_updater_if #(.N(N)) bus ();

    priority_matrix_updater #(.N(N), .STARVE_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit check_en = 1'b0;

    // Reference state: beats relation, loss counts, and the one event in flight.
    bit [N-1:0] exp_m [N];
    int         cnt   [N];
    int         pend_age = -1;
    bit [N-1:0] pend_g, pend_r;
    bit         exp_upd, exp_multi, exp_ovr;

    task automatic cmp_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
        end
    endtask

    task automatic cmp_row(input string name, input int i, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row%0d cyc=%0d got=%b exp=%b", name, i, cyc, got, exp);
        end
    endtask

    task automatic check_rows(input string name, input logic [N-1:0] r0, input logic [N-1:0] r1, input logic [N-1:0] r2);
        cmp_row(name, 0, bus.matrix_out[0], r0);
        cmp_row(name, 1, bus.matrix_out[1], r1);
        cmp_row(name, 2, bus.matrix_out[2], r2);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            for (int j = 0; j < N; j++) exp_m[i][j] = (j > i);
        end
        pend_age  = -1;
        exp_upd   = 1'b0;
        exp_multi = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic model_resolve();
        bit oh;
        bit found;
        oh    = ($countones(pend_g) == 1);
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pend_r[i] && !(oh && pend_g[i])) cnt[i] = (cnt[i] + 1 > LIM) ? LIM : cnt[i] + 1;
        end
        if (oh) begin
            for (int g = 0; g < N; g++) begin
                if (pend_g[g]) begin
                    cnt[g] = 0;
                    for (int k = 0; k < N; k++) begin
                        if (k != g) begin
                            exp_m[k][g] = 1'b1;
                            exp_m[g][k] = 1'b0;
                        end
                    end
                end
            end
        end
        for (int p = 0; p < N; p++) begin
            if (!found && cnt[p] == LIM) begin
                found  = 1'b1;
                cnt[p] = 0;
                for (int k = 0; k < N; k++) begin
                    if (k != p) begin
                        exp_m[p][k] = 1'b1;
                        exp_m[k][p] = 1'b0;
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        bit was_busy;
        cyc++;
        was_busy = (pend_age >= 0);
        exp_upd  = 1'b0;
        if (rst) begin
            model_reset();
        end else if (bus.cfg_load) begin
            if (bus.valid_gnt && was_busy) exp_ovr = 1'b1;
            for (int i = 0; i < N; i++) begin
                cnt[i]      = 0;
                exp_m[i][i] = 1'b0;
                for (int j = i + 1; j < N; j++) begin
                    exp_m[i][j] = bus.cfg_matrix[i][j];
                    exp_m[j][i] = ~bus.cfg_matrix[i][j];
                end
            end
            pend_age = -1;
        end else begin
            if (pend_age == 0) begin
                if ($countones(pend_g) > 1) begin
                    exp_multi = 1'b1;
                    pend_age  = -1;
                end else begin
                    pend_age = 1;
                end
            end else if (pend_age == 1) begin
                model_resolve();
                exp_upd  = 1'b1;
                pend_age = -1;
            end
            if (bus.valid_gnt) begin
                if (was_busy) begin
                    exp_ovr = 1'b1;
                end else begin
                    pend_g   = bus.gnt;
                    pend_r   = bus.req;
                    pend_age = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < N; i++) cmp_row("model_matrix", i, bus.matrix_out[i], exp_m[i]);
            cmp_bit("model_busy", bus.busy, pend_age >= 0);
            cmp_bit("model_upd_done", bus.upd_done, exp_upd);
            cmp_bit("model_err_multi", bus.err_multi_gnt, exp_multi);
            cmp_bit("model_err_overrun", bus.err_overrun, exp_ovr);
        end
    end

    task automatic drive(input bit vg, input bit [N-1:0] g, input bit [N-1:0] r, input bit cl);
        bus.valid_gnt = vg;
        bus.gnt       = g;
        bus.req       = r;
        bus.cfg_load  = cl;
        @(posedge clk);
        #1;
        bus.valid_gnt = 1'b0;
        bus.cfg_load  = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit [N-1:0] g, r;
        int sel;
        bus.valid_gnt = 1'b0;
        bus.gnt       = '0;
        bus.req       = '0;
        bus.cfg_load  = 1'b0;
        for (int i = 0; i < N; i++) bus.cfg_matrix[i] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        check_en = 1'b1;

        wait_neg(1);
        check_rows("reset", 3'b110, 3'b100, 3'b000);
        cmp_bit("reset_busy", bus.busy, 1'b0);
        cmp_bit("reset_multi", bus.err_multi_gnt, 1'b0);
        cmp_bit("reset_ovr", bus.err_overrun, 1'b0);

        // Single grant to requester 0: latency two edges, one-cycle done pulse.
        drive(1'b1, 3'b001, 3'b001, 1'b0);
        wait_neg(2);
        check_rows("grant0_pending", 3'b110, 3'b100, 3'b000);
        cmp_bit("grant0_busy", bus.busy, 1'b1);
        wait_neg(1);
        check_rows("grant0", 3'b000, 3'b101, 3'b001);
        cmp_bit("grant0_upd", bus.upd_done, 1'b1);
        wait_neg(1);
        cmp_bit("grant0_upd_gone", bus.upd_done, 1'b0);

        // Requester 2 loses twice and is promoted.
        drive(1'b1, 3'b001, 3'b101, 1'b0);
        wait_neg(3);
        check_rows("starve_1", 3'b000, 3'b101, 3'b001);
        drive(1'b1, 3'b001, 3'b101, 1'b0);
        wait_neg(3);
        check_rows("starve_2", 3'b000, 3'b001, 3'b011);

        // Multi-hot grant is flagged and ignored.
        drive(1'b1, 3'b011, 3'b011, 1'b0);
        wait_neg(3);
        cmp_bit("multi_flag", bus.err_multi_gnt, 1'b1);
        check_rows("multi_unchanged", 3'b000, 3'b001, 3'b011);
        wait_neg(2);
        cmp_bit("multi_sticky", bus.err_multi_gnt, 1'b1);

        // Second event while busy is dropped.
        drive(1'b1, 3'b010, 3'b010, 1'b0);
        drive(1'b1, 3'b100, 3'b100, 1'b0);
        wait_neg(2);
        cmp_bit("overrun_flag", bus.err_overrun, 1'b1);
        check_rows("overrun_first_only", 3'b010, 3'b000, 3'b011);

        // cfg_load during the apply cycle wins and suppresses the done pulse.
        bus.cfg_matrix[0] = 3'b000;
        bus.cfg_matrix[1] = 3'b100;
        bus.cfg_matrix[2] = 3'b000;
        drive(1'b1, 3'b001, 3'b001, 1'b0);
        wait_neg(1);
        @(posedge clk);
        #1;
        drive(1'b0, 3'b000, 3'b000, 1'b1);
        wait_neg(1);
        check_rows("cfg_load", 3'b000, 3'b101, 3'b001);
        cmp_bit("cfg_busy", bus.busy, 1'b0);
        cmp_bit("cfg_no_upd", bus.upd_done, 1'b0);
        cmp_bit("cfg_keeps_multi", bus.err_multi_gnt, 1'b1);
        cmp_bit("cfg_keeps_ovr", bus.err_overrun, 1'b1);
        wait_neg(1);
        cmp_bit("cfg_no_upd_later", bus.upd_done, 1'b0);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_neg(1);
        cmp_bit("rst_clears_multi", bus.err_multi_gnt, 1'b0);
        cmp_bit("rst_clears_ovr", bus.err_overrun, 1'b0);
        check_rows("rst_again", 3'b110, 3'b100, 3'b000);

        for (int it = 0; it < 3000; it++) begin
            sel = $urandom_range(0, 99);
            r   = N'($urandom_range(0, (1 << N) - 1));
            g   = '0;
            case ($urandom_range(0, 9))
                0: begin
                    case ($urandom_range(0, 3))
                        0: g = 3'b011;
                        1: g = 3'b101;
                        2: g = 3'b110;
                        default: g = 3'b111;
                    endcase
                end
                1, 2: g = '0;
                default: g[$urandom_range(0, N - 1)] = 1'b1;
            endcase
            if (sel < 2) begin
                rst = 1'b1;
                drive(1'b0, '0, '0, 1'b0);
                rst = 1'b0;
            end else if (sel < 6) begin
                for (int i = 0; i < N; i++) bus.cfg_matrix[i] = N'($urandom_range(0, (1 << N) - 1));
                drive(1'b0, g, r, 1'b1);
            end else if (sel < 56) begin
                drive(1'b1, g, r, 1'b0);
            end else begin
                drive(1'b0, g, r, 1'b0);
            end
        end
        wait_neg(4);
        check_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
